// File: rtl/fir_coef_loader.sv
// fir_coef_loader: assembles a coefficient set in a shadow bank and commits it atomically on a sample-boundary strobe.
// Optional FIR_COEF_LOADER_SYMM_EN: symmetric load of (N+1)/2 words, each mirrored into tap k and tap N-1-k.
module fir_coef_loader #(
   parameter int unsigned N     = 32,
   parameter int unsigned CNT_W = $clog2(N + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_first,
   input  logic [15:0]       s_data,
   input  logic              commit_allow,
   output logic [16*N-1:0]   filter_params,
   output logic              load_done,
   output logic              load_err,
   output logic              busy
);

   localparam int unsigned COEF_W = 16;
`ifdef FIR_COEF_LOADER_SYMM_EN
   localparam int unsigned LOAD_N = (N + 1) / 2;
`else
   localparam int unsigned LOAD_N = N;
`endif
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LOAD_N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    idx;
   logic [16*N-1:0]     shadow;

   logic                accept_c;
   logic                wr_en_c;
   logic [CNT_W-1:0]    wr_idx_c;

   // A first-flagged word always lands in tap 0; otherwise the running index is used.
   always_comb begin
      accept_c = s_valid && s_ready;
      wr_en_c  = accept_c && (s_first || (state == LOAD));
      wr_idx_c = s_first ? '0 : idx;
   end

   // Shadow bank: decoded per-tap write, optionally mirrored about the centre tap.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
      end else if (wr_en_c) begin
         for (int m = 0; m < int'(N); m++) begin
`ifdef FIR_COEF_LOADER_SYMM_EN
            if ((wr_idx_c == CNT_W'(m)) || (wr_idx_c == CNT_W'(int'(N) - 1 - m)))
               shadow[COEF_W*m +: COEF_W] <= s_data;
`else
            if (wr_idx_c == CNT_W'(m))
               shadow[COEF_W*m +: COEF_W] <= s_data;
`endif
         end
      end
   end

   // Framing FSM with registered handshake, status and pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         s_ready       <= 1'b1;
         busy          <= 1'b0;
         load_done     <= 1'b0;
         load_err      <= 1'b0;
         filter_params <= '0;
      end else begin
         load_done <= 1'b0;
         load_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  if (!s_first) begin
                     load_err <= 1'b1;
                  end else if (LOAD_N == 1) begin
                     state   <= PEND;
                     idx     <= '0;
                     s_ready <= 1'b0;
                     busy    <= 1'b1;
                  end else begin
                     state <= LOAD;
                     idx   <= CNT_W'(1);
                     busy  <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (accept_c) begin
                  if (s_first) begin
                     // Restart: the new tap 0 is already written, the old partial frame gets overwritten.
                     load_err <= 1'b1;
                     idx      <= CNT_W'(1);
                  end else if (idx == LAST_IDX) begin
                     state   <= PEND;
                     idx     <= '0;
                     s_ready <= 1'b0;
                  end else begin
                     idx <= idx + CNT_W'(1);
                  end
               end
            end
            PEND: begin
               if (commit_allow) begin
                  filter_params <= shadow;
                  load_done     <= 1'b1;
                  state         <= IDLE;
                  s_ready       <= 1'b1;
                  busy          <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               idx     <= '0;
               s_ready <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: directed table/sequences plus randomized traffic checked against a frame-level reference model.
module tb_fir_coef_loader;

`ifdef FIR_COEF_LOADER_SYMM_EN
   localparam int unsigned N      = 5;
   localparam bit          SYMM   = 1'b1;
`else
   localparam int unsigned N      = 4;
   localparam bit          SYMM   = 1'b0;
`endif
   localparam int unsigned LOAD_N = SYMM ? (N + 1) / 2 : N;

   logic              clk;
   logic              rst;
   logic              s_valid;
   logic              s_ready;
   logic              s_first;
   logic [15:0]       s_data;
   logic              commit_allow;
   logic [16*N-1:0]   filter_params;
   logic              load_done;
   logic              load_err;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // Reference model: words collected so far in the current frame, and whether a full set awaits commit.
   logic [15:0] m_shadow [N];
   logic [15:0] m_active [N];
   int          m_got;
   bit          m_pending;
   bit          m_done;
   bit          m_err;

   fir_coef_loader #(.N(N)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_first       (s_first),
      .s_data        (s_data),
      .commit_allow  (commit_allow),
      .filter_params (filter_params),
      .load_done     (load_done),
      .load_err      (load_err),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [16*N-1:0] pack_active();
      logic [16*N-1:0] r;
      for (int m = 0; m < int'(N); m++) r[16*m +: 16] = m_active[m];
      return r;
   endfunction

   task automatic model_write(input int k);
      m_shadow[k] = s_data;
      if (SYMM) m_shadow[int'(N) - 1 - k] = s_data;
   endtask

   task automatic model_reset();
      for (int m = 0; m < int'(N); m++) begin
         m_shadow[m] = '0;
         m_active[m] = '0;
      end
      m_got     = 0;
      m_pending = 1'b0;
      m_done    = 1'b0;
      m_err     = 1'b0;
   endtask

   // Advance the model by one edge using the current inputs, clock the DUT, then compare.
   task automatic tick();
      if (rst) begin
         model_reset();
      end else begin
         m_done = 1'b0;
         m_err  = 1'b0;
         if (m_pending) begin
            if (commit_allow) begin
               for (int m = 0; m < int'(N); m++) m_active[m] = m_shadow[m];
               m_done    = 1'b1;
               m_pending = 1'b0;
            end
         end else if (s_valid) begin
            if (s_first) begin
               if (m_got > 0) m_err = 1'b1;
               model_write(0);
               m_got = 1;
            end else if (m_got == 0) begin
               m_err = 1'b1;
            end else begin
               model_write(m_got);
               m_got++;
            end
            if (m_got == int'(LOAD_N)) begin
               m_pending = 1'b1;
               m_got     = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      check("model_s_ready",   128'(s_ready),       128'(!m_pending));
      check("model_busy",      128'(busy),          128'(m_pending || (m_got > 0)));
      check("model_load_done", 128'(load_done),     128'(m_done));
      check("model_load_err",  128'(load_err),      128'(m_err));
      check("model_params",    128'(filter_params), 128'(pack_active()));
   endtask

   task automatic drive(input logic v, input logic f, input logic [15:0] d, input logic c);
      s_valid      = v;
      s_first      = f;
      s_data       = d;
      commit_allow = c;
      tick();
   endtask

   typedef struct {
      logic        v;
      logic        f;
      logic [15:0] d;
      logic        c;
      logic        e_ready;
      logic        e_busy;
      logic        e_done;
      logic        e_err;
   } vec_t;

   vec_t tbl [7];

   initial begin
      rst = 1'b1;
      s_valid = 1'b0;
      s_first = 1'b0;
      s_data = '0;
      commit_allow = 1'b0;
      model_reset();

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16'h0, 1'b0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      check("reset_params", 128'(filter_params), 128'(0));
      check("reset_ready",  128'(s_ready),       128'(1));
      check("reset_busy",   128'(busy),          128'(0));
      check("reset_pulses", 128'({load_done, load_err}), 128'(0));

`ifdef FIR_COEF_LOADER_SYMM_EN
      // Symmetric load: three words fill five taps.
      drive(1'b1, 1'b1, 16'd1, 1'b1);
      drive(1'b1, 1'b0, 16'd2, 1'b1);
      drive(1'b1, 1'b0, 16'd3, 1'b1);
      check("symm_pend_ready", 128'(s_ready), 128'(0));
      drive(1'b0, 1'b0, 16'd0, 1'b1);
      check("symm_done",   128'(load_done),     128'(1));
      check("symm_params", 128'(filter_params), 128'(80'h0001_0002_0003_0002_0001));
      drive(1'b0, 1'b0, 16'd0, 1'b0);
      check("symm_idle", 128'({busy, load_done}), 128'(0));
`else
      // Basic load, commit tied high.
      drive(1'b1, 1'b1, 16'd1, 1'b1);
      drive(1'b1, 1'b0, 16'd2, 1'b1);
      drive(1'b1, 1'b0, 16'd3, 1'b1);
      drive(1'b1, 1'b0, 16'd4, 1'b1);
      check("basic_pend_ready", 128'(s_ready), 128'(0));
      check("basic_pre_params", 128'(filter_params), 128'(0));
      drive(1'b0, 1'b0, 16'd0, 1'b1);
      check("basic_done",   128'(load_done),     128'(1));
      check("basic_params", 128'(filter_params), 128'(64'h0004_0003_0002_0001));
      drive(1'b0, 1'b0, 16'd0, 1'b1);
      check("basic_done_once", 128'({load_done, busy}), 128'(0));

      // Held commit: PEND ignores incoming words until commit_allow rises.
      drive(1'b1, 1'b1, 16'hFFFF, 1'b0);
      drive(1'b1, 1'b0, 16'd2, 1'b0);
      drive(1'b1, 1'b0, 16'd3, 1'b0);
      drive(1'b1, 1'b0, 16'd4, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 16'h1234, 1'b0);
         check("held_ready",  128'(s_ready),       128'(0));
         check("held_busy",   128'(busy),          128'(1));
         check("held_params", 128'(filter_params), 128'(64'h0004_0003_0002_0001));
      end
      drive(1'b0, 1'b0, 16'd0, 1'b1);
      check("held_done",   128'(load_done),     128'(1));
      check("held_params_commit", 128'(filter_params), 128'(64'h0004_0003_0002_FFFF));

      // Framing error: restart on a second first-flagged word.
      tbl[0] = '{1'b1, 1'b1, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 16'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 16'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 16'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 16'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].v, tbl[i].f, tbl[i].d, tbl[i].c);
         check($sformatf("tbl%0d_ready", i), 128'(s_ready),   128'(tbl[i].e_ready));
         check($sformatf("tbl%0d_busy", i),  128'(busy),      128'(tbl[i].e_busy));
         check($sformatf("tbl%0d_done", i),  128'(load_done), 128'(tbl[i].e_done));
         check($sformatf("tbl%0d_err", i),   128'(load_err),  128'(tbl[i].e_err));
      end
      check("frame_params", 128'(filter_params), 128'(64'h0008_0007_0006_0005));

      // Stray word in IDLE, then reset mid-load.
      drive(1'b1, 1'b0, 16'h0055, 1'b0);
      check("stray_err",  128'(load_err), 128'(1));
      check("stray_busy", 128'(busy),     128'(0));
      drive(1'b1, 1'b1, 16'd10, 1'b0);
      drive(1'b1, 1'b0, 16'd11, 1'b0);
      check("midload_busy", 128'(busy), 128'(1));
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'd0, 1'b0);
      rst = 1'b0;
      check("midrst_params", 128'(filter_params), 128'(0));
      check("midrst_idle",   128'({busy, s_ready}), 128'(2'b01));
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(199) == 0);
         drive(1'($urandom_range(9) < 7), 1'($urandom_range(9) < 2),
               16'($urandom), 1'($urandom_range(9) < 3));
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
